// File: rtl/twf_mul_ctrl.sv
// twf_mul_ctrl: beat sequencer and valid/ready controller for the twiddle multiplier stage.
// Optional synchronous clear port `clr` when TWF_MUL_CTRL_SYNC_CLR_EN is defined.
module twf_mul_ctrl #(
   parameter  int DEPTH      = 16,
   parameter  int ADDR_WIDTH = 9,
   parameter  int N_POINTS   = 512,
   localparam int BEATS      = N_POINTS / DEPTH,
   localparam int CW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef TWF_MUL_CTRL_SYNC_CLR_EN
   input  logic                  clr,
`endif
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic                  mul_en,
   output logic [ADDR_WIDTH-1:0] mul_addr,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  dout_last,
   output logic                  frame_done,
   output logic                  busy,
   output logic [CW-1:0]         beat_cnt
);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dv_q, dv_d, last_q, last_d, fd_q, fd_d;
   logic          acc, hs, cnt_max, clr_w;
`ifdef TWF_MUL_CTRL_SYNC_CLR_EN
   assign clr_w = clr;
`else
   assign clr_w = 1'b0;
`endif
   // The multiplier output register is the only buffer, so accept only when it is free or draining.
   assign din_ready  = (state_q != FLUSH) && (!dv_q || dout_ready);
   assign acc        = din_valid && din_ready && !clr_w;
   assign hs         = dv_q && dout_ready;
   assign cnt_max    = cnt_q == CW'(BEATS - 1);
   assign mul_en     = acc;
   assign mul_addr   = ADDR_WIDTH'(32'(cnt_q) * DEPTH);
   assign dout_valid = dv_q;
   assign dout_last  = last_q;
   assign frame_done = fd_q;
   assign busy       = state_q != IDLE;
   assign beat_cnt   = cnt_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dv_d    = dv_q;
      last_d  = last_q;
      fd_d    = 1'b0;
      if (acc) begin
         cnt_d   = cnt_max ? '0 : cnt_q + 1'b1;
         dv_d    = 1'b1;
         last_d  = cnt_max;
         state_d = cnt_max ? FLUSH : RUN;
      end else if (hs) begin
         dv_d   = 1'b0;
         last_d = 1'b0;
      end
      if (state_q == FLUSH && hs && last_q) begin
         state_d = IDLE;
         fd_d    = 1'b1;
      end
      if (clr_w) begin
         state_d = IDLE;
         cnt_d   = '0;
         dv_d    = 1'b0;
         last_d  = 1'b0;
         fd_d    = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dv_q    <= 1'b0;
         last_q  <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dv_q    <= dv_d;
         last_q  <= last_d;
         fd_q    <= fd_d;
      end
   end
endmodule

// File: tb/tb_twf_mul_ctrl.sv
// tb_twf_mul_ctrl: directed and random stimulus against a frame-level model of twf_mul_ctrl.
module tb_twf_mul_ctrl;
   localparam int DEPTH = 16, AW = 9, NP = 512, BEATS = NP / DEPTH, CW = $clog2(BEATS);
   logic clk = 1'b0, rst_n = 1'b0, din_valid = 1'b0, dout_ready = 1'b0, clr_s = 1'b0;
   logic din_ready, mul_en, dout_valid, dout_last, frame_done, busy;
   logic [AW-1:0] mul_addr;
   logic [CW-1:0] beat_cnt;
   int total = 0, bad = 0;
   // Model: k = beats accepted in the current frame (BEATS while draining), plus the holding buffer.
   int k = 0, hidx = 0;
   bit hv = 1'b0, fd = 1'b0;

   twf_mul_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .N_POINTS(NP)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef TWF_MUL_CTRL_SYNC_CLR_EN
      .clr(clr_s),
`endif
      .din_valid(din_valid), .din_ready(din_ready), .mul_en(mul_en), .mul_addr(mul_addr),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
      .frame_done(frame_done), .busy(busy), .beat_cnt(beat_cnt));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input bit dv, input bit dr);
      bit rdy, acc;
      rdy = (k < BEATS) && (!hv || dr);
      acc = dv && rdy && !clr_s;
      chk("din_ready", 32'(din_ready), 32'(rdy));
      chk("mul_en", 32'(mul_en), 32'(acc));
      chk("mul_addr", 32'(mul_addr), 32'((k % BEATS) * DEPTH));
      chk("dout_valid", 32'(dout_valid), 32'(hv));
      chk("dout_last", 32'(dout_last), 32'(hv && hidx == BEATS - 1));
      chk("frame_done", 32'(frame_done), 32'(fd));
      chk("busy", 32'(busy), 32'(k != 0));
      chk("beat_cnt", 32'(beat_cnt), 32'(k % BEATS));
   endtask

   task automatic cycle(input bit dv, input bit dr);
      bit rdy, acc, hs;
      din_valid  = dv;
      dout_ready = dr;
      #1;
      check_outs(dv, dr);
      rdy = (k < BEATS) && (!hv || dr);
      acc = dv && rdy && !clr_s;
      hs  = hv && dr;
      @(posedge clk);
      if (clr_s) begin
         k = 0; hv = 1'b0; fd = 1'b0;
      end else begin
         fd = hs && hidx == BEATS - 1;
         if (acc) begin
            hv = 1'b1; hidx = k; k++;
         end else if (hs) hv = 1'b0;
         if (fd) k = 0;
      end
      #1;
   endtask

   initial begin
      #12;
      check_outs(1'b0, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // Full-speed frame, then drain and frame_done.
      for (int i = 0; i < 35; i++) cycle(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
      // Stall of five cycles after a few beats.
      for (int i = 0; i < 45; i++) cycle(1'b1, !(i >= 4 && i < 9));
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
      // Reach FLUSH with dout_ready mostly low, hold, then drain.
      for (int i = 0; i < 200 && k < BEATS; i++) cycle(1'b1, i % 3 == 0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
      // din_valid toggling.
      for (int i = 0; i < 8; i++) cycle(i % 2 == 0, 1'b1);
      // Random traffic.
      for (int i = 0; i < 600; i++) cycle(1'($urandom_range(0, 1)), ($urandom % 4) != 0);
      // Asynchronous reset at beat 10.
      for (int i = 0; i < 200 && k != 10; i++) cycle(1'b1, 1'b1);
      din_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      k = 0; hv = 1'b0; fd = 1'b0;
      check_outs(1'b0, 1'b1);
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);
`ifdef TWF_MUL_CTRL_SYNC_CLR_EN
      for (int i = 0; i < 200 && k != 20; i++) cycle(1'b1, 1'b1);
      clr_s = 1'b1;
      cycle(1'b1, 1'b1);
      clr_s = 1'b0;
      cycle(1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
